mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the MIPS32 core; sole driver of the register file write port (writeEnable/writeAddr/writeData).
- Registers ALU results, waits on multi-cycle data-memory reads, byte/halfword-extracts and sign/zero-extends load data, and raises a stall request while a load is outstanding.
- Flags misaligned loads and memory timeouts.

Parameters:
ACK_TIMEOUT, 16, max cycles spent in WAIT before abort (>=2)
CNT_W, 5, width of timeout counter (must hold ACK_TIMEOUT-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_i  input  1  MEM stage holds a valid instruction
stall_i  input  1  hazard unit holds MEM; WB takes a bubble
flush_i  input  1  discard in-flight instruction/load
wreg_i  input  1  instruction writes a GPR
waddr_i  input  5  destination GPR
wdata_i  input  32  ALU result (non-load)
memRead_i  input  1  instruction is a load
loadType_i  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101-111 reserved
addrLow_i  input  2  effective address [1:0]
memAck_i  input  1  read data valid this cycle
memRdata_i  input  32  aligned word from data memory
writeEnable_o  output  1  register file write strobe
writeAddr_o  output  5  register file write address
writeData_o  output  32  register file write data
stallReq_o  output  1  load outstanding; freeze upstream
busErr_o  output  1  one-cycle pulse: misaligned, reserved type, or timeout

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0, writeEnable_o=0, writeAddr_o=0, writeData_o=0, busErr_o=0. Reset in WAIT aborts the load, no write.
- All outputs registered except stallReq_o = (state==WAIT), combinational from state.
- writeEnable_o and busErr_o are one-cycle pulses; default 0 each cycle. writeAddr_o/writeData_o update only on a write, else hold.
- Write is never issued to address 0: writeEnable_o = wreg && addr!=0 at capture.
- Priority per edge: rst > flush_i > stall_i > memAck_i > timeout.
- IDLE, accept = valid_i && !stall_i && !flush_i:
  - !memRead_i: write wdata_i to waddr_i next cycle (latency 1).
  - memRead_i && memAck_i: write extracted data next cycle; stay IDLE.
  - memRead_i && !memAck_i: capture waddr/wreg/loadType/addrLow, counter<=0, go WAIT.
  - no accept: bubble (writeEnable_o=0).
- WAIT (upstream frozen; valid_i/wdata_i ignored):
  - flush_i: to IDLE, no write.
  - memAck_i: write extracted memRdata_i next cycle, to IDLE.
  - counter==ACK_TIMEOUT-1: busErr_o pulse, no write, to IDLE.
  - else counter+1.
- Extraction, little-endian lanes: byte = memRdata_i[8*addrLow+7 : 8*addrLow]; half = addrLow[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
- Alignment checked at capture: LH/LHU with addrLow[0]=1, LW with addrLow!=0, or reserved loadType -> busErr_o pulse, no write, never enters WAIT (ack, if any, ignored).
- Ack arriving in IDLE with no load accepted: ignored.

Test Plan:
- Reset then ALU op valid_i=1, wreg_i=1, waddr_i=5, wdata_i=0x12345678 -> next cycle writeEnable_o=1, writeAddr_o=5, writeData_o=0x12345678; following cycle writeEnable_o=0.
- LB addrLow_i=3, ack after 3 cycles with memRdata_i=0x80FF_0011 -> stallReq_o=1 for 3 cycles, then write 0xFFFFFF80; LBU same -> 0x00000080.
- LH addrLow_i=2 memRdata_i=0x8001_7FFF, same-cycle ack -> stallReq_o never 1, write 0xFFFF8001; LHU addrLow_i=0 -> 0x00007FFF.
- LW addrLow_i=2 -> busErr_o pulse, writeEnable_o=0, stallReq_o=0; loadType_i=110 -> same.
- Load, no ack, ACK_TIMEOUT=16 -> stallReq_o high 16 cycles, busErr_o pulse, no write, back in IDLE; flush_i in 4th WAIT cycle -> IDLE, no write, no busErr_o.
- waddr_i=0 with wreg_i=1 -> writeEnable_o stays 0; stall_i=1 with valid_i=1 -> bubble; rst asserted in WAIT -> all outputs 0, stallReq_o=0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: instruction/load-data inputs and register-file write port.
interface mem_wb_stage_if;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        memRead_i;
  logic [2:0]  loadType_i;
  logic [1:0]  addrLow_i;
  logic        memAck_i;
  logic [31:0] memRdata_i;
  logic        writeEnable_o;
  logic [4:0]  writeAddr_o;
  logic [31:0] writeData_o;
  logic        stallReq_o;
  logic        busErr_o;

  modport master (
    output valid_i, stall_i, flush_i, wreg_i, waddr_i, wdata_i,
           memRead_i, loadType_i, addrLow_i, memAck_i, memRdata_i,
    input  writeEnable_o, writeAddr_o, writeData_o, stallReq_o, busErr_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, wreg_i, waddr_i, wdata_i,
           memRead_i, loadType_i, addrLow_i, memAck_i, memRdata_i,
    output writeEnable_o, writeAddr_o, writeData_o, stallReq_o, busErr_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: registers ALU results, waits on multi-cycle loads, extracts/extends
// load data and drives the register file write port.
module mem_wb_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ld_wreg_q, ld_wreg_d;
  logic [4:0]         ld_waddr_q, ld_waddr_d;
  logic [2:0]         ld_type_q, ld_type_d;
  logic [1:0]         ld_alow_q, ld_alow_d;
  logic               we_q, we_d;
  logic [4:0]         wa_q, wa_d;
  logic [31:0]        wd_q, wd_d;
  logic               err_q, err_d;

  function automatic logic [31:0] extract(input logic [2:0] lt, input logic [1:0] al,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{al, 3'b000} +: 8];
    h = al[1] ? w[31:16] : w[15:0];
    case (lt)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {24'h0, b};
      3'b010:  extract = {{16{h[15]}}, h};
      3'b011:  extract = {16'h0, h};
      default: extract = w;
    endcase
  endfunction

  // Reserved types and misaligned half/word accesses abort before touching WAIT.
  function automatic logic bad_access(input logic [2:0] lt, input logic [1:0] al);
    bad_access = (lt > 3'd4) ||
                 ((lt[2:1] == 2'b01) && al[0]) ||
                 ((lt == 3'd4) && (al != 2'b00));
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_wreg_d  = ld_wreg_q;
    ld_waddr_d = ld_waddr_q;
    ld_type_d  = ld_type_q;
    ld_alow_d  = ld_alow_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i && !bus.stall_i && !bus.flush_i) begin
          if (!bus.memRead_i) begin
            if (bus.wreg_i && bus.waddr_i != 5'd0) begin
              we_d = 1'b1;
              wa_d = bus.waddr_i;
              wd_d = bus.wdata_i;
            end
          end else if (bad_access(bus.loadType_i, bus.addrLow_i)) begin
            err_d = 1'b1;
          end else if (bus.memAck_i) begin
            if (bus.wreg_i && bus.waddr_i != 5'd0) begin
              we_d = 1'b1;
              wa_d = bus.waddr_i;
              wd_d = extract(bus.loadType_i, bus.addrLow_i, bus.memRdata_i);
            end
          end else begin
            ld_wreg_d  = bus.wreg_i;
            ld_waddr_d = bus.waddr_i;
            ld_type_d  = bus.loadType_i;
            ld_alow_d  = bus.addrLow_i;
            cnt_d      = '0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (bus.memAck_i) begin
          state_d = IDLE;
          if (ld_wreg_q && ld_waddr_q != 5'd0) begin
            we_d = 1'b1;
            wa_d = ld_waddr_q;
            wd_d = extract(ld_type_q, ld_alow_q, bus.memRdata_i);
          end
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_wreg_q  <= 1'b0;
      ld_waddr_q <= 5'd0;
      ld_type_q  <= 3'd0;
      ld_alow_q  <= 2'd0;
      we_q       <= 1'b0;
      wa_q       <= 5'd0;
      wd_q       <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_wreg_q  <= ld_wreg_d;
      ld_waddr_q <= ld_waddr_d;
      ld_type_q  <= ld_type_d;
      ld_alow_q  <= ld_alow_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  assign bus.writeEnable_o = we_q;
  assign bus.writeAddr_o   = wa_q;
  assign bus.writeData_o   = wd_q;
  assign bus.busErr_o      = err_q;
  assign bus.stallReq_o    = (state_q == WAIT);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases from the plan plus random ops.
module tb_mem_wb_stage;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();
  mem_wb_stage #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { bit err; bit [4:0] addr; bit [31:0] data; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  bit [4:0]  last_wa = 0;
  bit [31:0] last_wd = 0;

  // Reference: plain arithmetic on the byte/half lanes.
  function automatic bit [31:0] ref_load(bit [2:0] lt, bit [1:0] al, bit [31:0] w);
    int unsigned bv, hv;
    bv = (w >> (int'(al) * 8)) & 32'hFF;
    hv = (w >> (al[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd0: return (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
      3'd1: return bv;
      3'd2: return (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
      3'd3: return hv;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_bad(bit [2:0] lt, bit [1:0] al);
    return (lt >= 5) || ((lt == 2 || lt == 3) && (al % 2 == 1)) || (lt == 4 && al != 0);
  endfunction

  task automatic check(string name, bit [63:0] got, bit [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: pops an expectation whenever a write or error pulse appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.stallReq_o) stall_cnt++;
      if (bus.writeEnable_o || bus.busErr_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out we=%0b err=%0b addr=%0d data=%08h",
                   bus.writeEnable_o, bus.busErr_o, bus.writeAddr_o, bus.writeData_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.busErr_o !== e.err || bus.writeEnable_o !== !e.err ||
              (!e.err && (bus.writeAddr_o !== e.addr || bus.writeData_o !== e.data))) begin
            errors++;
            $display("FAIL out got we=%0b err=%0b a=%0d d=%08h want err=%0b a=%0d d=%08h",
                     bus.writeEnable_o, bus.busErr_o, bus.writeAddr_o, bus.writeData_o,
                     e.err, e.addr, e.data);
          end
          if (!e.err) begin
            last_wa = e.addr;
            last_wd = e.data;
          end
        end
      end else begin
        checks++;
        if (bus.writeAddr_o !== last_wa || bus.writeData_o !== last_wd) begin
          errors++;
          $display("FAIL hold got a=%0d d=%08h want a=%0d d=%08h",
                   bus.writeAddr_o, bus.writeData_o, last_wa, last_wd);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.wreg_i = 0;
    bus.waddr_i = 0; bus.wdata_i = 0; bus.memRead_i = 0; bus.loadType_i = 0;
    bus.addrLow_i = 0; bus.memAck_i = 0; bus.memRdata_i = 0;
  endtask

  // d: 0 = ack with capture, k = ack in k-th WAIT cycle, >TO = never. fl: flush in WAIT cycle fl (0 = none).
  task automatic op(bit mr, bit [2:0] lt, bit [1:0] al, bit wr, bit [4:0] wa,
                    bit [31:0] wd, bit [31:0] rd, int d, int fl);
    int exp_stall;
    exp_t e;
    bit waits;
    exp_stall = 0;
    waits = mr && !ref_bad(lt, al) && d != 0;
    e.err = 0; e.addr = wa; e.data = 0;
    if (!mr) begin
      e.data = wd;
      if (wr && wa != 0) sb.push_back(e);
    end else if (ref_bad(lt, al)) begin
      e.err = 1;
      sb.push_back(e);
    end else if (d == 0) begin
      e.data = ref_load(lt, al, rd);
      if (wr && wa != 0) sb.push_back(e);
    end else if (fl != 0 && fl <= d && fl <= TO) begin
      exp_stall = fl;
    end else if (d <= TO) begin
      exp_stall = d;
      e.data = ref_load(lt, al, rd);
      if (wr && wa != 0) sb.push_back(e);
    end else begin
      exp_stall = TO;
      e.err = 1;
      sb.push_back(e);
    end
    stall_cnt = 0;
    bus.valid_i = 1; bus.memRead_i = mr; bus.loadType_i = lt; bus.addrLow_i = al;
    bus.wreg_i = wr; bus.waddr_i = wa; bus.wdata_i = wd; bus.memRdata_i = rd;
    bus.memAck_i = (d == 0);
    @(posedge clk); #1;
    bus.memAck_i = 0;
    if (waits) begin
      for (int k = 1; k <= TO; k++) begin
        bus.waddr_i = 5'($urandom); bus.wdata_i = $urandom; bus.wreg_i = 1;
        if (k == fl) begin
          bus.flush_i = 1; @(posedge clk); #1; bus.flush_i = 0; break;
        end
        if (k == d) begin
          bus.memAck_i = 1; @(posedge clk); #1; bus.memAck_i = 0; break;
        end
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(bus.writeEnable_o), 0);
    check("rst_err", 64'(bus.busErr_o), 0);
    check("rst_stall", 64'(bus.stallReq_o), 0);
    check("rst_addr_data", {27'd0, bus.writeAddr_o, bus.writeData_o}, 0);
    rst = 0;

    op(0, 0, 0, 1, 5, 32'h12345678, 0, 0, 0);
    op(1, 3'd0, 2'd3, 1, 6, 0, 32'h80FF0011, 3, 0);
    op(1, 3'd1, 2'd3, 1, 7, 0, 32'h80FF0011, 3, 0);
    op(1, 3'd2, 2'd2, 1, 8, 0, 32'h80017FFF, 0, 0);
    op(1, 3'd3, 2'd0, 1, 9, 0, 32'h80017FFF, 0, 0);
    op(1, 3'd4, 2'd2, 1, 10, 0, 32'hDEADBEEF, 0, 0);
    op(1, 3'd6, 2'd0, 1, 11, 0, 32'hDEADBEEF, 2, 0);
    op(1, 3'd4, 2'd0, 1, 12, 0, 32'hCAFEF00D, 99, 0);
    op(1, 3'd4, 2'd0, 1, 13, 0, 32'hCAFEF00D, 10, 4);
    op(1, 3'd4, 2'd0, 1, 14, 0, 32'hA5A5A5A5, TO, 0);
    op(0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0);

    // stall_i and flush_i in IDLE both produce a bubble
    stall_cnt = 0;
    bus.valid_i = 1; bus.wreg_i = 1; bus.waddr_i = 3; bus.wdata_i = 32'h55AA55AA;
    bus.stall_i = 1; @(posedge clk); #1;
    bus.stall_i = 0; bus.flush_i = 1; bus.memRead_i = 1; bus.loadType_i = 3'd4;
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk); #1;
    check("bubble_stall", 64'(stall_cnt), 0);

    // reset while a load is outstanding
    bus.valid_i = 1; bus.memRead_i = 1; bus.loadType_i = 3'd4; bus.wreg_i = 1; bus.waddr_i = 20;
    @(posedge clk); #1;
    idle_inputs();
    check("wait_entered", 64'(bus.stallReq_o), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("rstw_stall", 64'(bus.stallReq_o), 0);
    check("rstw_outs", {25'd0, bus.writeEnable_o, bus.busErr_o, bus.writeAddr_o, bus.writeData_o}, 0);
    last_wa = 0; last_wd = 0;
    rst = 0;
    bus.memAck_i = 1; bus.memRdata_i = 32'h11111111;
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      bit [2:0] lt; bit [1:0] al; bit mr; int d, fl;
      mr = $urandom_range(0, 3) != 0;
      lt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      al = 2'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        if (lt == 3'd4) al = 0;
        else if (lt == 3'd2 || lt == 3'd3) al[0] = 0;
      end
      d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
      op(mr, lt, al, $urandom_range(0, 5) != 0, 5'($urandom_range(0, 31)),
         $urandom, $urandom, d, fl);
    end

    check("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
